// File: rtl/pio_pkg.sv
// Shared constants for the pio_edge_irq peripheral: the word-address map
// and the edge-type encodings used by the EDGE_TYPE parameter.
package pio_pkg;

   localparam logic [2:0] ADDR_DATA = 3'd0;
   localparam logic [2:0] ADDR_DIR  = 3'd1;
   localparam logic [2:0] ADDR_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE = 3'd3;
   localparam logic [2:0] ADDR_SET  = 3'd4;
   localparam logic [2:0] ADDR_CLR  = 3'd5;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, one-cycle-delayed "prev" copy and per-bit edge pulse
// generation for the PIO inputs. The pulse is combinational from the last
// synchroniser stage and prev, so the parent captures it on the next edge.
module pio_sync_edge
   import pio_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] async_i,
   output logic [DATA_WIDTH-1:0] sync_o,
   output logic [DATA_WIDTH-1:0] edge_o
);

   logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] prev_q;
   logic [DATA_WIDTH-1:0] rise;
   logic [DATA_WIDTH-1:0] fall;

   // Shift the asynchronous inputs through the flop chain and keep prev.
   // NOTE: non-blocking assignments let every stage sample the old value of
   // its neighbour; blocking ones would collapse the chain into one flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the chain is a handful of flops, not a RAM, so it is reset
         // element by element; a real memory array would be left unreset.
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= async_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise   = sync_o & ~prev_q;
   assign fall   = ~sync_o & prev_q;
   assign edge_o = (EDGE_TYPE == EDGE_RISE) ? rise :
                   (EDGE_TYPE == EDGE_FALL) ? fall : (rise | fall);

endmodule

// File: rtl/pio_edge_irq.sv
// Avalon-MM slave PIO with output data/direction registers, synchronised
// inputs, sticky edge capture (write-1-to-clear) and a masked level irq.
// Optional macro PIO_BITSETCLR_EN adds the outset (4) and outclear (5)
// write-only registers; without it those addresses are reserved.
module pio_edge_irq
   import pio_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    EDGE_TYPE   = EDGE_RISE,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic [DATA_WIDTH-1:0] out_oe,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] dir_q, dir_d;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [DATA_WIDTH-1:0] edge_q, edge_d;
   logic [DATA_WIDTH-1:0] edge_clr;
   logic                  irq_q, irq_d;
   logic [31:0]           rdata_q, rdata_d;

   logic [DATA_WIDTH-1:0] sync_in;
   logic [DATA_WIDTH-1:0] edge_pulse;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign wdata        = writedata[DATA_WIDTH-1:0];
   // Upper write-data bits are deliberately ignored.
   assign unused_wdata = ^writedata;

   pio_sync_edge #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk     (clk),
      .reset   (reset),
      .async_i (in_port),
      .sync_o  (sync_in),
      .edge_o  (edge_pulse)
   );

   // Register-file writes, edge capture and irq next-state.
   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      data_d   = data_q;
      dir_d    = dir_q;
      mask_d   = mask_q;
      edge_clr = '0;
      if (wr_en) begin
         case (address)
            ADDR_DATA: data_d   = wdata;
            ADDR_DIR:  dir_d    = wdata;
            ADDR_MASK: mask_d   = wdata;
            ADDR_EDGE: edge_clr = wdata;
`ifdef PIO_BITSETCLR_EN
            ADDR_SET:  data_d   = data_q | wdata;
            ADDR_CLR:  data_d   = data_q & ~wdata;
`else
            ADDR_SET, ADDR_CLR: ;
`endif
            default: ;
         endcase
      end
      // A new edge overrides a simultaneous clear of the same bit.
      edge_d = (edge_q & ~edge_clr) | edge_pulse;
      irq_d  = |(edge_q & mask_q);
   end

   // Read mux, registered every cycle from the current address.
   always_comb begin
      rdata_d = '0;
      case (address)
         ADDR_DATA: rdata_d[DATA_WIDTH-1:0] = sync_in;
         ADDR_DIR:  rdata_d[DATA_WIDTH-1:0] = dir_q;
         ADDR_MASK: rdata_d[DATA_WIDTH-1:0] = mask_q;
         ADDR_EDGE: rdata_d[DATA_WIDTH-1:0] = edge_q;
         default:   rdata_d = '0;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= RESET_VALUE;
         dir_q   <= '0;
         mask_q  <= '0;
         edge_q  <= '0;
         irq_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         data_q  <= data_d;
         dir_q   <= dir_d;
         mask_q  <= mask_d;
         edge_q  <= edge_d;
         irq_q   <= irq_d;
         rdata_q <= rdata_d;
      end
   end

   assign out_port = data_q;
   assign out_oe   = dir_q;
   assign irq      = irq_q;
   assign readdata = rdata_q;

endmodule

// File: tb/tb_pio_edge_irq.sv
// Scoreboard bench for pio_edge_irq (DATA_WIDTH=8, rising edges,
// RESET_VALUE=0x30, two synchroniser stages). Stimulus pushes expected
// values tagged with the cycle they are due; a monitor on the falling edge
// pops and compares them. Build with PIO_BITSETCLR_EN to cover set/clear.
module tb_pio_edge_irq;

   localparam int         DW    = 8;
   localparam logic [7:0] RST_V = 8'h30;

   typedef enum int {K_RD, K_OUT, K_OE, K_IRQ} kind_e;
   typedef struct {
      kind_e       kind;
      int          due;
      logic [31:0] exp;
      string       name;
   } sb_item_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [DW-1:0] in_port;
   logic [DW-1:0] out_port;
   logic [DW-1:0] out_oe;
   logic          irq;

   int       cyc   = 0;
   int       total = 0;
   int       bad   = 0;
   sb_item_t sb_q[$];

   pio_edge_irq #(
      .DATA_WIDTH  (DW),
      .EDGE_TYPE   (0),
      .RESET_VALUE (RST_V),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .out_port   (out_port),
      .out_oe     (out_oe),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compare every scoreboard entry that falls due this cycle.
   always @(negedge clk) begin
      int          i;
      logic [31:0] act;
      i = 0;
      while (i < sb_q.size()) begin
         if (sb_q[i].due == cyc) begin
            case (sb_q[i].kind)
               K_RD:    act = readdata;
               K_OUT:   act = {24'd0, out_port};
               K_OE:    act = {24'd0, out_oe};
               default: act = {31'd0, irq};
            endcase
            check(sb_q[i].name, act, sb_q[i].exp);
            sb_q.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_at(input kind_e k, input int dly, input logic [31:0] exp, input string name);
      sb_item_t it;
      it.kind = k;
      it.due  = cyc + dly;
      it.exp  = exp;
      it.name = name;
      sb_q.push_back(it);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      step();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
      address = a;
      expect_at(K_RD, 1, exp, name);
      step();
   endtask

   initial begin
      reset      = 1'b1;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;
      step(3);

      // Reset state and full address sweep.
      expect_at(K_OUT, 1, 32'h30, "rst_out_port");
      expect_at(K_OE,  1, 32'h00, "rst_out_oe");
      expect_at(K_IRQ, 1, 32'h0,  "rst_irq");
      expect_at(K_RD,  1, 32'h0,  "rst_readdata");
      step();
      reset = 1'b0;
      for (int a = 0; a < 8; a++) bus_read(3'(a), 32'h0, $sformatf("rst_rd_addr%0d", a));

      // Data and direction registers, input readback.
      bus_write(3'd0, 32'hFFFF_FFA5);
      bus_write(3'd1, 32'h0000_000F);
      expect_at(K_OUT, 1, 32'hA5, "wr_out_port");
      expect_at(K_OE,  1, 32'h0F, "wr_out_oe");
      in_port = 8'hA5;
      step(3);
      bus_read(3'd0, 32'hA5, "rd_sync_in");
      bus_read(3'd1, 32'h0F, "rd_dir");
      bus_read(3'd3, 32'hA5, "rd_edge_multi");
      in_port = 8'h02;
      step(4);
      bus_read(3'd3, 32'hA7, "rd_edge_no_fall");
      bus_write(3'd3, 32'hFF);
      bus_read(3'd3, 32'h00, "rd_edge_cleared");
      bus_read(3'd0, 32'h02, "rd_sync_in2");

      // Masked bit0 rising edge: capture after 3 clocks, irq one later.
      bus_write(3'd2, 32'h01);
      in_port = 8'h03;
      expect_at(K_IRQ, 3, 32'h0, "irq_before_edge");
      expect_at(K_IRQ, 4, 32'h1, "irq_after_edge");
      step(2);
      bus_read(3'd3, 32'h00, "edge_at_2clk");
      bus_read(3'd3, 32'h01, "edge_at_3clk");
      in_port = 8'h01;
      step(4);
      bus_read(3'd3, 32'h01, "edge_bit1_fall_ignored");
      expect_at(K_IRQ, 1, 32'h1, "irq_held");

      // Clear colliding with a new edge on the same bit: edge wins.
      in_port = 8'h00;
      step(4);
      in_port = 8'h01;
      step(2);
      expect_at(K_IRQ, 1, 32'h1, "irq_collide_0");
      expect_at(K_IRQ, 2, 32'h1, "irq_collide_1");
      bus_write(3'd3, 32'h01);
      bus_read(3'd3, 32'h01, "edge_collide_kept");
      // Plain clear: bit drops, irq follows one cycle later.
      expect_at(K_IRQ, 1, 32'h1, "irq_clear_lag");
      expect_at(K_IRQ, 2, 32'h0, "irq_clear_fall");
      bus_write(3'd3, 32'h01);
      bus_read(3'd3, 32'h00, "edge_cleared");

      // Bit set/clear registers, or reserved behaviour without them.
      bus_write(3'd0, 32'h30);
`ifdef PIO_BITSETCLR_EN
      bus_write(3'd4, 32'h03);
      expect_at(K_OUT, 1, 32'h33, "outset");
      bus_write(3'd5, 32'h20);
      expect_at(K_OUT, 1, 32'h13, "outclear");
`else
      bus_write(3'd4, 32'hFF);
      expect_at(K_OUT, 1, 32'h30, "addr4_reserved");
      bus_write(3'd5, 32'hFF);
      expect_at(K_OUT, 1, 32'h30, "addr5_reserved");
`endif
      bus_write(3'd6, 32'hFF);
      bus_read(3'd4, 32'h0, "rd_addr4");
      bus_read(3'd5, 32'h0, "rd_addr5");
      bus_read(3'd6, 32'h0, "rd_addr6");
      bus_read(3'd7, 32'h0, "rd_addr7");

      // Reset in the middle of activity with all edges pending.
      bus_write(3'd1, 32'hFF);
      bus_write(3'd2, 32'hFF);
      in_port = 8'h00;
      step(4);
      in_port = 8'hFF;
      step(4);
      bus_read(3'd3, 32'hFF, "edge_all");
      expect_at(K_IRQ, 1, 32'h1, "irq_pre_reset");
      step();
      reset = 1'b1;
      expect_at(K_OUT, 1, 32'h30, "mid_rst_out_port");
      expect_at(K_OE,  1, 32'h00, "mid_rst_out_oe");
      expect_at(K_IRQ, 1, 32'h0,  "mid_rst_irq");
      expect_at(K_RD,  1, 32'h0,  "mid_rst_readdata");
      step();
      reset = 1'b0;
      bus_read(3'd3, 32'h0, "mid_rst_edge");
      bus_read(3'd2, 32'h0, "mid_rst_mask");
      bus_read(3'd1, 32'h0, "mid_rst_dir");
      step(3);

      while (sb_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL %s: never compared, due cyc %0d now %0d", sb_q[0].name, sb_q[0].due, cyc);
         void'(sb_q.pop_front());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
